// File: rtl/ps2_morse_encoder_fifo.sv
// PS/2 set-2 make-code filter, Morse lookup, symbol FIFO and unit-timed keyer.
// Key, busy and sidetone outputs are registered; the lookup result is registered before the FIFO push.
module ps2_morse_encoder_fifo #(
    parameter int unsigned UNIT_CYCLES = 10_000_000,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TONE_DIV    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    ps2_received_data,
    input  logic                          ps2_received_data_strb,
    output logic                          morse_code_out,
    output logic                          tone_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(3 * UNIT_CYCLES + 1);
    localparam int unsigned TW   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int unsigned TDM1 = (TONE_DIV > 0) ? TONE_DIV - 1 : 0;

    // len == 0 marks the word-space symbol; pat bit 0 is the first element, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } sym_t;

    typedef enum logic [1:0] {F_NORMAL, F_BREAK, F_EXT} fstate_t;
    typedef enum logic [2:0] {K_IDLE, K_MARK, K_EGAP, K_CGAP, K_WORD} kstate_t;

    fstate_t         fstate_q, fstate_d;
    logic            push_q, push_d;
    sym_t            psym_q, psym_d;
    sym_t            rom_sym;
    logic            rom_hit;

    sym_t            mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            pop, full, wr_en;
    sym_t            head;

    kstate_t         kstate_q, kstate_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      pat_q, pat_d;
    logic [2:0]      rem_q, rem_d;
    logic            word_ext_q, word_ext_d;
    logic            morse_q, morse_d;
    logic            busy_q, busy_d;
    logic            tone_q, tone_d;
    logic [TW-1:0]   tdiv_q, tdiv_d;

    // Scan code to Morse ROM
    always_comb begin
        rom_hit = 1'b1;
        rom_sym = '0;
        case (ps2_received_data)
            8'h1C: rom_sym = {3'd2, 5'b00010}; // A .-
            8'h32: rom_sym = {3'd4, 5'b00001}; // B
            8'h21: rom_sym = {3'd4, 5'b00101}; // C
            8'h23: rom_sym = {3'd3, 5'b00001}; // D
            8'h24: rom_sym = {3'd1, 5'b00000}; // E
            8'h2B: rom_sym = {3'd4, 5'b00100}; // F
            8'h34: rom_sym = {3'd3, 5'b00011}; // G
            8'h33: rom_sym = {3'd4, 5'b00000}; // H
            8'h43: rom_sym = {3'd2, 5'b00000}; // I
            8'h3B: rom_sym = {3'd4, 5'b01110}; // J
            8'h42: rom_sym = {3'd3, 5'b00101}; // K
            8'h4B: rom_sym = {3'd4, 5'b00010}; // L
            8'h3A: rom_sym = {3'd2, 5'b00011}; // M
            8'h31: rom_sym = {3'd2, 5'b00001}; // N
            8'h44: rom_sym = {3'd3, 5'b00111}; // O
            8'h4D: rom_sym = {3'd4, 5'b00110}; // P
            8'h15: rom_sym = {3'd4, 5'b01011}; // Q
            8'h2D: rom_sym = {3'd3, 5'b00010}; // R
            8'h1B: rom_sym = {3'd3, 5'b00000}; // S
            8'h2C: rom_sym = {3'd1, 5'b00001}; // T
            8'h3C: rom_sym = {3'd3, 5'b00100}; // U
            8'h2A: rom_sym = {3'd4, 5'b01000}; // V
            8'h1D: rom_sym = {3'd3, 5'b00110}; // W
            8'h22: rom_sym = {3'd4, 5'b01001}; // X
            8'h35: rom_sym = {3'd4, 5'b01101}; // Y
            8'h1A: rom_sym = {3'd4, 5'b00011}; // Z
            8'h45: rom_sym = {3'd5, 5'b11111}; // 0
            8'h16: rom_sym = {3'd5, 5'b11110}; // 1
            8'h1E: rom_sym = {3'd5, 5'b11100}; // 2
            8'h26: rom_sym = {3'd5, 5'b11000}; // 3
            8'h25: rom_sym = {3'd5, 5'b10000}; // 4
            8'h2E: rom_sym = {3'd5, 5'b00000}; // 5
            8'h36: rom_sym = {3'd5, 5'b00001}; // 6
            8'h3D: rom_sym = {3'd5, 5'b00011}; // 7
            8'h3E: rom_sym = {3'd5, 5'b00111}; // 8
            8'h46: rom_sym = {3'd5, 5'b01111}; // 9
            8'h29: rom_sym = {3'd0, 5'b00000}; // space
            default: rom_hit = 1'b0;
        endcase
    end

    // Make-code filter: break and extended prefixes swallow the following byte
    always_comb begin
        fstate_d = fstate_q;
        push_d   = 1'b0;
        psym_d   = psym_q;
        if (ps2_received_data_strb) begin
            case (fstate_q)
                F_NORMAL: begin
                    if (ps2_received_data == 8'hF0) begin
                        fstate_d = F_BREAK;
                    end else if (ps2_received_data == 8'hE0) begin
                        fstate_d = F_EXT;
                    end else begin
                        push_d = rom_hit;
                        psym_d = rom_sym;
                    end
                end
                F_BREAK: fstate_d = F_NORMAL;
                F_EXT:   fstate_d = (ps2_received_data == 8'hF0) ? F_BREAK : F_NORMAL;
                default: fstate_d = F_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q <= F_NORMAL;
            push_q   <= 1'b0;
            psym_q   <= '0;
        end else begin
            fstate_q <= fstate_d;
            push_q   <= push_d;
            psym_q   <= psym_d;
        end
    end

    // Symbol FIFO; a push while full only lands when the keyer pops in the same cycle
    assign head       = mem[rd_ptr_q];
    assign pop        = (kstate_q == K_IDLE) && (count_q != '0);
    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign wr_en      = push_q && (!full || pop);
    assign overflow_d = overflow_q | (push_q && full && !pop);

    always_comb begin
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= psym_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Keyer: cnt_q holds remaining cycles minus one; WORD runs 3 units then 1 more
    always_comb begin
        kstate_d   = kstate_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        rem_d      = rem_q;
        word_ext_d = word_ext_q;
        tone_d     = 1'b0;
        tdiv_d     = '0;
        case (kstate_q)
            K_IDLE: begin
                if (pop) begin
                    if (head.len == 3'd0) begin
                        kstate_d   = K_WORD;
                        cnt_d      = CW'(3 * UNIT_CYCLES - 1);
                        word_ext_d = 1'b1;
                    end else begin
                        kstate_d = K_MARK;
                        pat_d    = head.pat;
                        rem_d    = head.len;
                        cnt_d    = head.pat[0] ? CW'(3 * UNIT_CYCLES - 1) : CW'(UNIT_CYCLES - 1);
                    end
                end
            end
            K_MARK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (rem_q > 3'd1) begin
                    kstate_d = K_EGAP;
                    cnt_d    = CW'(UNIT_CYCLES - 1);
                    pat_d    = {1'b0, pat_q[4:1]};
                    rem_d    = rem_q - 3'd1;
                end else begin
                    kstate_d = K_CGAP;
                    cnt_d    = CW'(3 * UNIT_CYCLES - 1);
                end
            end
            K_EGAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    kstate_d = K_MARK;
                    cnt_d    = pat_q[0] ? CW'(3 * UNIT_CYCLES - 1) : CW'(UNIT_CYCLES - 1);
                end
            end
            K_CGAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    kstate_d = K_IDLE;
                end
            end
            K_WORD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (word_ext_q) begin
                    cnt_d      = CW'(UNIT_CYCLES - 1);
                    word_ext_d = 1'b0;
                end else begin
                    kstate_d = K_IDLE;
                end
            end
            default: kstate_d = K_IDLE;
        endcase

        morse_d = (kstate_d == K_MARK);
        busy_d  = (kstate_d != K_IDLE);

        // Sidetone restarts low on every mark entry
        if (TONE_DIV > 0 && kstate_d == K_MARK && kstate_q == K_MARK) begin
            if (tdiv_q == TW'(TDM1)) begin
                tone_d = ~tone_q;
                tdiv_d = '0;
            end else begin
                tone_d = tone_q;
                tdiv_d = tdiv_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kstate_q   <= K_IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            rem_q      <= '0;
            word_ext_q <= 1'b0;
            morse_q    <= 1'b0;
            busy_q     <= 1'b0;
            tone_q     <= 1'b0;
            tdiv_q     <= '0;
        end else begin
            kstate_q   <= kstate_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            rem_q      <= rem_d;
            word_ext_q <= word_ext_d;
            morse_q    <= morse_d;
            busy_q     <= busy_d;
            tone_q     <= tone_d;
            tdiv_q     <= tdiv_d;
        end
    end

    assign morse_code_out = morse_q;
    assign tone_out       = tone_q;
    assign busy           = busy_q;
    assign fifo_count     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_ps2_morse_encoder_fifo.sv
// Bench for ps2_morse_encoder_fifo: directed filter/overflow/reset steps plus random
// character strings checked cycle by cycle against a waveform built from ITU dot/dash strings.
module tb_ps2_morse_encoder_fifo;

    localparam int unsigned U  = 4;
    localparam int unsigned D  = 4;
    localparam int unsigned TD = 1;
    localparam int unsigned LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       strb;
    logic       morse, tone, busy, overflow;
    logic [$clog2(D):0] count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit         log_en = 1'b0;
    logic [5:0] log_q [$];
    logic [2:0] exp_q [$];
    logic [7:0] seq_q [$];
    logic [7:0] keys  [$];
    string      mref  [logic [7:0]];

    ps2_morse_encoder_fifo #(.UNIT_CYCLES(U), .FIFO_DEPTH(D), .TONE_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps2_received_data(data), .ps2_received_data_strb(strb),
        .morse_code_out(morse), .tone_out(tone), .busy(busy),
        .fifo_count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (log_en) log_q.push_back({count, morse, busy, tone});

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data = b;
        strb = 1'b1;
        tick();
        strb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Expected {key, busy, tone} per cycle from the first pop onwards
    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < seq_q.size(); i++) begin
            string s = mref[seq_q[i]];
            if (s == " ") begin
                repeat (4 * U) exp_q.push_back(3'b010);
            end else begin
                for (int j = 0; j < s.len(); j++) begin
                    int dur = (s[j] == 8'h2D) ? 3 * U : U;
                    for (int k = 0; k < dur; k++)
                        exp_q.push_back({2'b11, ((k / TD) % 2) == 1});
                    if (j < s.len() - 1) repeat (U) exp_q.push_back(3'b010);
                end
                repeat (3 * U) exp_q.push_back(3'b010);
            end
            if (i < seq_q.size() - 1) exp_q.push_back(3'b000);
        end
        repeat (8) exp_q.push_back(3'b000);
    endtask

    task automatic run_seq(input string name);
        int t = 0;
        int need;
        build_expected();
        need = LAT + exp_q.size();
        log_q.delete();
        log_en = 1'b1;
        foreach (seq_q[i]) send(seq_q[i]);
        foreach (seq_q[i]) begin
            send(8'hF0);
            send(seq_q[i]);
        end
        send(8'hE0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h24);
        while (log_q.size() < need && t < 5000) begin
            tick();
            t++;
        end
        log_en = 1'b0;
        check({name, "_timeout"}, 32'(log_q.size() >= need), 32'd1);
        if (log_q.size() >= need) begin
            check({name, "_push_lat"}, 32'(log_q[LAT-1][5:3]), 32'd1);
            check({name, "_pop_busy"}, 32'(log_q[LAT][1]), 32'd1);
            check({name, "_pre_busy"}, 32'(log_q[LAT-1][1]), 32'd0);
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("%s_wave[%0d]", name, i), 32'(log_q[LAT+i][2:0]), 32'(exp_q[i]));
                if (log_q[LAT+i][2:0] !== exp_q[i]) break;
            end
        end
        check({name, "_count_end"}, 32'(count), 32'd0);
        check({name, "_ovf_end"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int n0, t, ovf_low, busy_seen;
        mref[8'h1C] = ".-";    mref[8'h32] = "-...";  mref[8'h21] = "-.-.";  mref[8'h23] = "-..";
        mref[8'h24] = ".";     mref[8'h2B] = "..-.";  mref[8'h34] = "--.";   mref[8'h33] = "....";
        mref[8'h43] = "..";    mref[8'h3B] = ".---";  mref[8'h42] = "-.-";   mref[8'h4B] = ".-..";
        mref[8'h3A] = "--";    mref[8'h31] = "-.";    mref[8'h44] = "---";   mref[8'h4D] = ".--.";
        mref[8'h15] = "--.-";  mref[8'h2D] = ".-.";   mref[8'h1B] = "...";   mref[8'h2C] = "-";
        mref[8'h3C] = "..-";   mref[8'h2A] = "...-";  mref[8'h1D] = ".--";   mref[8'h22] = "-..-";
        mref[8'h35] = "-.--";  mref[8'h1A] = "--..";
        mref[8'h45] = "-----"; mref[8'h16] = ".----"; mref[8'h1E] = "..---"; mref[8'h26] = "...--";
        mref[8'h25] = "....-"; mref[8'h2E] = "....."; mref[8'h36] = "-...."; mref[8'h3D] = "--...";
        mref[8'h3E] = "---.."; mref[8'h46] = "----.";
        mref[8'h29] = " ";
        foreach (mref[k]) keys.push_back(k);

        rst_n = 1'b0;
        data  = 8'h00;
        strb  = 1'b0;
        repeat (2) tick();
        check("rst_morse", 32'(morse), 32'd0);
        check("rst_tone", 32'(tone), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Break, extended and unmapped codes never push
        send(8'hF0); send(8'h24);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h1C);
        send(8'h0D);
        repeat (4) begin
            tick();
            check("filt_count", 32'(count), 32'd0);
            check("filt_busy", 32'(busy), 32'd0);
        end

        seq_q = {8'h24};               run_seq("E");
        seq_q = {8'h1C};               run_seq("A");
        seq_q = {8'h24, 8'h29, 8'h24}; run_seq("E_sp_E");
        seq_q = {8'h29, 8'h29, 8'h45}; run_seq("sp_sp_0");
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 5);
            seq_q.delete();
            repeat (n) seq_q.push_back(keys[$urandom_range(0, keys.size() - 1)]);
            run_seq($sformatf("rnd%0d", r));
        end

        // Overflow: six back-to-back codes into a depth-4 queue, first char E
        send(8'h24);
        n0 = cyc;
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h2B);
        tick();
        check("ovf_count_full", 32'(count), 32'(D));
        check("ovf_flag", 32'(overflow), 32'd1);
        while (cyc < n0 + 1 + U + 3 * U) tick();
        send(8'h16);
        check("full_pre_busy", 32'(busy), 32'd0);
        check("full_pre_count", 32'(count), 32'(D));
        tick();
        check("full_pushpop_count", 32'(count), 32'(D));
        check("full_pushpop_busy", 32'(busy), 32'd1);
        check("full_pushpop_morse", 32'(morse), 32'd1);
        t = 0;
        ovf_low = 0;
        while (!(count == 0 && busy == 1'b0) && t < 3000) begin
            tick();
            if (overflow !== 1'b1) ovf_low++;
            t++;
        end
        check("ovf_drain_timeout", 32'(t < 3000), 32'd1);
        check("ovf_sticky_cycles_low", 32'(ovf_low), 32'd0);
        check("ovf_sticky_end", 32'(overflow), 32'd1);

        // Asynchronous reset mid-dash with a symbol still queued
        do_reset();
        check("rst2_ovf", 32'(overflow), 32'd0);
        send(8'h2C);
        send(8'h24);
        t = 0;
        while (morse !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        check("dash_start_timeout", 32'(t < 50), 32'd1);
        repeat (5) tick();
        check("middash_busy", 32'(busy), 32'd1);
        check("middash_count", 32'(count), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_morse", 32'(morse), 32'd0);
        check("arst_tone", 32'(tone), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (30) begin
            tick();
            if (busy !== 1'b0 || count !== '0) busy_seen++;
        end
        check("arst_queue_lost", 32'(busy_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
